// File: rtl/game_ctrl_pkg.sv
// Shared types for the round controller: states, winner codes, tick width.
// Build option GAME_CTRL_OVERTIME_EN is consumed by game_ctrl.sv.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int TICK_W = 8;

    function automatic logic [1:0] judge(
        input logic [6:0] a,
        input logic [6:0] b
    );
        if (a > b)
            return WIN_P1;
        else if (b > a)
            return WIN_P2;
        else
            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/game_ctrl_sec_timer.sv
// Frame-to-second divider; tick fires on the frame where the count wraps.
module sec_timer
    import game_ctrl_pkg::*;
#(
    parameter int FRAMES = 60
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAMES - 1);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = !clr_i && !hold_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i || tick_o)
            cnt_d = '0;
        else if (!hold_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, all outputs registered.
// Define GAME_CTRL_OVERTIME_EN to play sudden-death overtime on a tie.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECS     = 90,
    parameter int COUNT_SECS     = 3,
    parameter int BASE_SPEED     = 3,
    parameter int MAX_SPEED      = 6,
    parameter int SPEEDUP_SECS   = 30
) (
    input  logic       FrameClk,
    input  logic       Reset_n,
    input  logic       StartKey,
    input  logic       Pause,
    input  logic [6:0] Score1,
    input  logic [6:0] Score2,
    output logic       SpawnEnable,
    output logic [2:0] Speed,
    output logic [1:0] State,
    output logic [7:0] TimeLeft,
    output logic [1:0] CountLeft,
    output logic [1:0] Winner
);

    localparam logic [7:0] ROUND_L  = 8'(ROUND_SECS);
    localparam logic [1:0] COUNT_L  = 2'(COUNT_SECS);
    localparam logic [2:0] BASE_L   = 3'(BASE_SPEED);
    localparam logic [2:0] MAX_L    = 3'(MAX_SPEED);
    localparam logic [7:0] SPD_LAST = 8'(SPEEDUP_SECS - 1);

    state_e     state_q, state_d;
    logic       ot_q, ot_d;
    logic       key_q;
    logic       spawn_q, spawn_d;
    logic [2:0] speed_q, speed_d;
    logic [7:0] time_q, time_d;
    logic [1:0] count_q, count_d;
    logic [1:0] win_q, win_d;
    logic [7:0] spd_cnt_q, spd_cnt_d;

    logic start_edge, tie, tick, clr, hold;

    assign start_edge = StartKey && !key_q;
    assign tie        = (Score1 == Score2);
    assign clr        = (state_q == S_IDLE) || (state_q == S_OVER) || ot_q;
    assign hold       = Pause && (state_q == S_PLAY) && !ot_q;

    sec_timer #(
        .FRAMES(FRAMES_PER_SEC)
    ) u_timer (
        .clk_i (FrameClk),
        .rst_ni(Reset_n),
        .clr_i (clr),
        .hold_i(hold),
        .tick_o(tick)
    );

    always_ff @(posedge FrameClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            ot_q      <= 1'b0;
            key_q     <= 1'b1;
            spawn_q   <= 1'b0;
            speed_q   <= BASE_L;
            time_q    <= ROUND_L;
            count_q   <= COUNT_L;
            win_q     <= WIN_NONE;
            spd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ot_q      <= ot_d;
            key_q     <= StartKey;
            spawn_q   <= spawn_d;
            speed_q   <= speed_d;
            time_q    <= time_d;
            count_q   <= count_d;
            win_q     <= win_d;
            spd_cnt_q <= spd_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ot_d    = ot_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge)
                    state_d = S_COUNT;
            end
            S_COUNT: begin
                if (tick && count_q == 2'd1)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                if (ot_q) begin
                    if (!tie) begin
                        state_d = S_OVER;
                        ot_d    = 1'b0;
                    end
                end else if (tick && time_q == 8'd1) begin
`ifdef GAME_CTRL_OVERTIME_EN
                    if (tie)
                        ot_d = 1'b1;
                    else
                        state_d = S_OVER;
`else
                    state_d = S_OVER;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        time_d    = time_q;
        count_d   = count_q;
        speed_d   = speed_q;
        spd_cnt_d = spd_cnt_q;
        win_d     = win_q;
        spawn_d   = (state_d == S_PLAY);
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    count_d = COUNT_L;
                    win_d   = WIN_NONE;
                end
            end
            S_COUNT: begin
                if (tick) begin
                    count_d = count_q - 2'd1;
                    if (state_d == S_PLAY) begin
                        time_d    = ROUND_L;
                        speed_d   = BASE_L;
                        spd_cnt_d = '0;
                    end
                end
            end
            S_PLAY: begin
                if (!ot_q && tick) begin
                    time_d = time_q - 8'd1;
                    // speed steps once per SPEEDUP_SECS seconds of play
                    if (spd_cnt_q == SPD_LAST) begin
                        spd_cnt_d = '0;
                        if (speed_q < MAX_L)
                            speed_d = speed_q + 3'd1;
                    end else begin
                        spd_cnt_d = spd_cnt_q + 8'd1;
                    end
                end
                if (state_d == S_OVER)
                    win_d = judge(Score1, Score2);
            end
            default: ;
        endcase
    end

    assign State       = state_q;
    assign SpawnEnable = spawn_q;
    assign Speed       = speed_q;
    assign TimeLeft    = time_q;
    assign CountLeft   = count_q;
    assign Winner      = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed round checks plus randomized model compare.
module tb_game_ctrl;

    localparam int FPS   = 4;
    localparam int ROUND = 5;
    localparam int COUNT = 3;
    localparam int SPDUP = 2;
    localparam int BASE  = 3;
    localparam int MAXS  = 4;
`ifdef GAME_CTRL_OVERTIME_EN
    localparam bit OT_EN = 1'b1;
`else
    localparam bit OT_EN = 1'b0;
`endif

    logic       FrameClk;
    logic       Reset_n;
    logic       StartKey;
    logic       Pause;
    logic [6:0] Score1;
    logic [6:0] Score2;
    logic       SpawnEnable;
    logic [2:0] Speed;
    logic [1:0] State;
    logic [7:0] TimeLeft;
    logic [1:0] CountLeft;
    logic [1:0] Winner;

    int total = 0;
    int bad   = 0;

    int m_st, m_ot, m_spd, m_tl, m_cl, m_win, m_el, m_prev, secs;
    bit sedge;

    game_ctrl #(
        .FRAMES_PER_SEC(FPS),
        .ROUND_SECS    (ROUND),
        .COUNT_SECS    (COUNT),
        .BASE_SPEED    (BASE),
        .MAX_SPEED     (MAXS),
        .SPEEDUP_SECS  (SPDUP)
    ) dut (
        .FrameClk   (FrameClk),
        .Reset_n    (Reset_n),
        .StartKey   (StartKey),
        .Pause      (Pause),
        .Score1     (Score1),
        .Score2     (Score2),
        .SpawnEnable(SpawnEnable),
        .Speed      (Speed),
        .State      (State),
        .TimeLeft   (TimeLeft),
        .CountLeft  (CountLeft),
        .Winner     (Winner)
    );

    initial FrameClk = 1'b0;
    always #5 FrameClk = ~FrameClk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge FrameClk);
        #1;
    endtask

    function automatic int win_of(input int a, input int b);
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    // Phase model: elapsed active frames since the phase began
    initial forever begin
        @(posedge FrameClk or negedge Reset_n);
        if (!Reset_n) begin
            m_st = 0; m_ot = 0; m_spd = BASE; m_tl = ROUND;
            m_cl = COUNT; m_win = 0; m_el = 0; m_prev = 1;
        end else begin
            sedge  = StartKey && (m_prev == 0);
            m_prev = int'(StartKey);
            case (m_st)
                0, 3: if (sedge) begin
                    m_st = 1; m_el = 0; m_cl = COUNT; m_win = 0;
                end
                1: begin
                    m_el++;
                    if (m_el == COUNT * FPS) begin
                        m_st = 2; m_el = 0; m_cl = 0;
                        m_tl = ROUND; m_spd = BASE;
                    end else begin
                        m_cl = COUNT - m_el / FPS;
                    end
                end
                default: begin
                    if (m_ot != 0) begin
                        if (Score1 != Score2) begin
                            m_win = win_of(Score1, Score2);
                            m_st = 3; m_ot = 0;
                        end
                    end else if (!Pause) begin
                        m_el++;
                        secs  = m_el / FPS;
                        m_tl  = ROUND - secs;
                        m_spd = BASE + secs / SPDUP;
                        if (m_spd > MAXS) m_spd = MAXS;
                        if (m_el == ROUND * FPS) begin
                            if (OT_EN && Score1 == Score2) begin
                                m_ot = 1;
                            end else begin
                                m_st = 3;
                                m_win = win_of(Score1, Score2);
                            end
                        end
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(posedge FrameClk);
        #1;
        chk("m_state", State, m_st);
        chk("m_spawn", SpawnEnable, (m_st == 2) ? 1 : 0);
        chk("m_speed", Speed, m_spd);
        chk("m_time", TimeLeft, m_tl);
        chk("m_count", CountLeft, m_cl);
        chk("m_winner", Winner, m_win);
    end

    initial begin
        Reset_n = 1'b0; StartKey = 1'b1; Pause = 1'b0;
        Score1 = 7'd0; Score2 = 7'd0;
        wait_edges(2);
        chk("rst_state", State, 0);
        chk("rst_spawn", SpawnEnable, 0);
        chk("rst_speed", Speed, 3);
        chk("rst_time", TimeLeft, 5);
        chk("rst_count", CountLeft, 3);
        chk("rst_win", Winner, 0);
        @(negedge FrameClk) Reset_n = 1'b1;
        wait_edges(5);
        chk("held_key_idle", State, 0);
        @(negedge FrameClk) begin
            StartKey = 1'b0; Score1 = 7'd9; Score2 = 7'd4;
        end

        // round 1: plain timeout, P1 wins
        @(negedge FrameClk) StartKey = 1'b1;
        wait_edges(1);
        chk("cd_enter", State, 1);
        chk("cd_3", CountLeft, 3);
        @(negedge FrameClk) StartKey = 1'b0;
        wait_edges(4);
        chk("cd_2", CountLeft, 2);
        wait_edges(4);
        chk("cd_1", CountLeft, 1);
        chk("cd_1_state", State, 1);
        wait_edges(4);
        chk("play_enter", State, 2);
        chk("play_spawn", SpawnEnable, 1);
        chk("play_time5", TimeLeft, 5);
        chk("play_speed3", Speed, 3);
        wait_edges(8);
        chk("play_time3", TimeLeft, 3);
        chk("play_speed4", Speed, 4);
        wait_edges(11);
        chk("play_time1", TimeLeft, 1);
        chk("play_last", State, 2);
        wait_edges(1);
        chk("over_state", State, 3);
        chk("over_time0", TimeLeft, 0);
        chk("over_win_p1", Winner, 1);
        chk("over_spawn", SpawnEnable, 0);
        chk("over_speed", Speed, 4);

        // round 2: key held, pause, tie
        @(negedge FrameClk) begin
            StartKey = 1'b1; Score1 = 7'd5; Score2 = 7'd5;
        end
        wait_edges(1);
        chk("r2_cd", State, 1);
        chk("r2_win_clr", Winner, 0);
        wait_edges(12);
        chk("r2_play", State, 2);
        wait_edges(6);
        chk("r2_time4", TimeLeft, 4);
        @(negedge FrameClk) Pause = 1'b1;
        wait_edges(10);
        chk("pause_time", TimeLeft, 4);
        chk("pause_speed", Speed, 3);
        chk("pause_state", State, 2);
        @(negedge FrameClk) Pause = 1'b0;
        wait_edges(13);
        chk("r2_time1", TimeLeft, 1);
        chk("r2_still_play", State, 2);
        wait_edges(1);
`ifdef GAME_CTRL_OVERTIME_EN
        chk("ot_state", State, 2);
        chk("ot_spawn", SpawnEnable, 1);
        chk("ot_time", TimeLeft, 0);
        @(negedge FrameClk) Score2 = 7'd6;
        wait_edges(1);
        chk("ot_over", State, 3);
        chk("ot_win_p2", Winner, 2);
        chk("ot_spawn_off", SpawnEnable, 0);
`else
        chk("tie_over", State, 3);
        chk("tie_win", Winner, 3);
`endif

        // round 3: reset in the middle of play
        @(negedge FrameClk) StartKey = 1'b0;
        @(negedge FrameClk) StartKey = 1'b1;
        wait_edges(16);
        chk("r3_play", State, 2);
        @(negedge FrameClk) Reset_n = 1'b0;
        #1;
        chk("midrst_state", State, 0);
        chk("midrst_spawn", SpawnEnable, 0);
        @(negedge FrameClk) Reset_n = 1'b1;
        wait_edges(3);
        chk("midrst_held", State, 0);

        repeat (4000) begin
            @(negedge FrameClk);
            Reset_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) StartKey = ~StartKey;
            Pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                Score1 = 7'($urandom_range(0, 7));
                Score2 = 7'($urandom_range(0, 7));
            end
        end
        @(negedge FrameClk) Reset_n = 1'b1;
        wait_edges(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, FrameClk edges per second tick.
REQ-002 Parameter ROUND_SECS, default 90, round length in seconds (2..255).
REQ-003 Parameter COUNT_SECS, default 3, pre-round countdown in seconds (1..3).
REQ-004 Parameter BASE_SPEED, default 3; MAX_SPEED, default 6; SPEEDUP_SECS, default 30, seconds between speed increments.
REQ-005 FrameClk  in  1  frame clock (one edge per video frame); sole clock.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 StartKey  in  1  level start request from keycode decode.
REQ-008 Pause  in  1  level; freezes round timing while high in PLAY.
REQ-009 Score1, Score2  in  7 each  player scores.
REQ-010 SpawnEnable  out  1  enables both player blocks.
REQ-011 Speed  out  3  player speed.
REQ-012 State  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3.
REQ-013 TimeLeft  out  8  seconds remaining in the round.
REQ-014 CountLeft  out  2  countdown digit.
REQ-015 Winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-016 A start edge SHALL be StartKey high on this edge and low on the previous edge; a held key SHALL produce one edge only.
REQ-017 IDLE: start edge -> COUNTDOWN, with CountLeft=COUNT_SECS, frame counter=0.
REQ-018 The frame counter SHALL count 0..FRAMES_PER_SEC-1 and wrap; a second tick SHALL occur on the edge where it wraps.
REQ-019 COUNTDOWN: each tick SHALL decrement CountLeft; a tick with CountLeft=1 -> PLAY, with TimeLeft=ROUND_SECS, Speed=BASE_SPEED, speed counter=0, frame counter=0.
REQ-020 PLAY: each tick SHALL decrement TimeLeft; a tick with TimeLeft=1 SHALL set TimeLeft=0 and enter OVER on the same edge.
REQ-021 PLAY: the speed counter SHALL increment on each tick and wrap at SPEEDUP_SECS-1; on wrap, Speed SHALL increment, saturating at MAX_SPEED.
REQ-022 Pause high in PLAY SHALL hold the frame, speed and TimeLeft counters; Pause SHALL be ignored in other states.
REQ-023 Entry to OVER SHALL latch Winner from an unsigned compare of Score1 and Score2: 01 if Score1 is greater, 10 if Score2 is greater, 11 if equal.
REQ-024 OVER: start edge -> COUNTDOWN, with Winner cleared to 00.
REQ-025 A start edge in COUNTDOWN or PLAY SHALL be ignored.
REQ-026 SpawnEnable SHALL be 1 only in PLAY (and OVERTIME, REQ-031).
- Entry to PLAY from any state is via COUNTDOWN, so SpawnEnable is low for at least COUNT_SECS seconds between rounds; players see a fresh spawn and a score clear.
REQ-027 All outputs SHALL be registered; they change only on FrameClk edges.
REQ-028 Arithmetic SHALL be unsigned; no counter SHALL underflow or exceed its stated range.

Reset
REQ-029 Reset_n low SHALL asynchronously set the following, at any point including mid-round:
- State=IDLE, SpawnEnable=0, Speed=BASE_SPEED;
- TimeLeft=ROUND_SECS, CountLeft=COUNT_SECS, Winner=00;
- all counters 0, start-edge history=1 (a key held through reset produces no edge).

Configuration
REQ-030 The macro GAME_CTRL_OVERTIME_EN selects tie handling; with it undefined, a tie at timeout SHALL give Winner=11 and OVER.
REQ-031 With GAME_CTRL_OVERTIME_EN defined, a tie at timeout SHALL instead enter OVERTIME (encoded as State=2, internal flag set).
- In OVERTIME: SpawnEnable=1, TimeLeft=0, Speed held.
- On the first edge where Score1 differs from Score2: latch Winner (01 or 10) and go to OVER.
- Pause freezes nothing in OVERTIME.

Structure
REQ-032 A shared package SHALL hold the state enum, the Winner encodings and the second-tick counter width.
REQ-033 One sub-module SHALL be used: sec_timer (frame counter, tick output, hold input).

Verification (FRAMES_PER_SEC=4, ROUND_SECS=5, COUNT_SECS=3, SPEEDUP_SECS=2, BASE=3, MAX=4)
REQ-034 Reset, one StartKey pulse -> COUNTDOWN; CountLeft 3,2,1 at 4-edge spacing; PLAY on edge 12 after start; SpawnEnable rises on that edge.
REQ-035 In PLAY, no pause -> TimeLeft 5..1, then 0 with OVER on edge 20; Speed 3 -> 4 after 2 s, then held at 4.
REQ-036 Pause held for 10 edges mid-PLAY -> TimeLeft and Speed frozen; OVER delayed by exactly 10 edges.
REQ-037 Score1=9, Score2=4 at timeout -> Winner=01; scores 5/5 without the macro -> Winner=11.
REQ-038 With the macro, scores 5/5 at timeout -> SpawnEnable stays 1; Score2 becomes 6 -> Winner=10 and OVER on the next edge.
REQ-039 StartKey held high through reset release and through COUNTDOWN/PLAY -> no state change; Reset_n low mid-PLAY -> IDLE immediately and SpawnEnable=0.
